// File: rtl/mux_tree_pipe.sv
// Pipelined N:1 multiplexer built as a binary tree of registered 2:1 stages.
// Stage k halves the lane count using sel bit k, so sel[0] resolves first.
// A single global advance enable stalls the whole tree under backpressure.
module mux_tree_pipe #(
  parameter int WIDTH = 8,
  parameter int SEL_W = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [(2**SEL_W)*WIDTH-1:0] din,
  input  logic [SEL_W-1:0]            sel,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [WIDTH-1:0]            dout,
  output logic [SEL_W-1:0]            out_sel
);

  localparam int N = 2**SEL_W;

  logic adv;

  // Whole pipeline moves when the output slot is empty or being drained.
  always_comb begin
    adv      = !out_valid || out_ready;
    in_ready = adv;
  end

  for (genvar k = 0; k < SEL_W; k++) begin : g_stg
    localparam int NI = N >> k;
    localparam int NO = NI / 2;

    logic [NI*WIDTH-1:0] lane_in;
    logic                vld_in;
    logic [SEL_W-1:0]    sel_in;

    logic [NO*WIDTH-1:0] lane_d, lane_q;
    logic                vld_d, vld_q;
    logic [SEL_W-1:0]    sel_d, sel_q;

    // ---- stage k input: din/sel for stage 0, previous stage otherwise ----
    if (k == 0) begin : g_src
      assign lane_in = din;
      assign vld_in  = in_valid;
      assign sel_in  = sel;
    end else begin : g_chain
      assign lane_in = g_stg[k-1].lane_q;
      assign vld_in  = g_stg[k-1].vld_q;
      assign sel_in  = g_stg[k-1].sel_q;
    end

    // Valid follows its predecessor on advance; data/sel load only on a valid item.
    always_comb begin
      lane_d = lane_q;
      vld_d  = vld_q;
      sel_d  = sel_q;
      if (adv) begin
        vld_d = vld_in;
        if (vld_in) begin
          sel_d = sel_in;
          for (int j = 0; j < NO; j++) begin
            lane_d[j*WIDTH +: WIDTH] = sel_in[k] ? lane_in[(2*j+1)*WIDTH +: WIDTH]
                                                 : lane_in[(2*j)*WIDTH +: WIDTH];
          end
        end
      end
    end

    // Stage k register; reset clears data too so dout/out_sel read 0 after reset.
    always_ff @(posedge clk) begin
      if (rst) begin
        lane_q <= '0;
        vld_q  <= 1'b0;
        sel_q  <= '0;
      end else begin
        lane_q <= lane_d;
        vld_q  <= vld_d;
        sel_q  <= sel_d;
      end
    end
  end

  // ---- final stage drives the consumer side ----
  always_comb begin
    out_valid = g_stg[SEL_W-1].vld_q;
    dout      = g_stg[SEL_W-1].lane_q;
    out_sel   = g_stg[SEL_W-1].sel_q;
  end

endmodule
